// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

  // IDLE waits for a word; SHIFT has a frame on the serial line.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width: enough to index WIDTH bits, never less than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the serializer, bundled as one port.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             shift_en;
  logic             q;
  logic             q_valid;
  logic             busy;
  logic             done;

  // Producer / line-rate side: offers words and paces the bit rate.
  modport master (
    output load_valid,
    output load_data,
    output shift_en,
    input  load_ready,
    input  q,
    input  q_valid,
    input  busy,
    input  done
  );

  // Serializer side.
  modport slave (
    input  load_valid,
    input  load_data,
    input  shift_en,
    output load_ready,
    output q,
    output q_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. A word accepted over the load handshake
// is sent one bit per enabled clock on q; back-to-back words stream with no gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  piso_serializer_if.slave  bus
);

  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state,   state_n;
  logic [WIDTH-1:0]   shreg,   shreg_n;
  logic [CNT_W-1:0]   bit_cnt, cnt_n;
  logic               q_r,     q_n;
  logic               qv_r,    qv_n;
  logic               done_r,  done_n;
  logic               last_bit;
  logic               accept;

  // The bit that goes on the line first for a given word.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the leading position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign last_bit       = (state == SHIFT) && (bit_cnt == LAST);
  assign bus.load_ready = (state == IDLE) || (last_bit && bus.shift_en);
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.q       = q_r;
  assign bus.q_valid = qv_r;
  assign bus.busy    = (state == SHIFT);
  assign bus.done    = done_r;

  // Next-state logic: load a word, advance a bit, or retire/reload at frame end.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = bit_cnt;
    q_n     = q_r;
    qv_n    = qv_r;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = bus.load_data;
          cnt_n   = '0;
          q_n     = lead_bit(bus.load_data);
          qv_n    = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (last_bit) begin
            done_n = 1'b1;
            if (accept) begin
              shreg_n = bus.load_data;
              cnt_n   = '0;
              q_n     = lead_bit(bus.load_data);
              qv_n    = 1'b1;
            end else begin
              state_n = IDLE;
              shreg_n = '0;
              cnt_n   = '0;
              q_n     = 1'b0;
              qv_n    = 1'b0;
            end
          end else begin
            shreg_n = advance(shreg);
            cnt_n   = bit_cnt + CNT_W'(1);
            q_n     = lead_bit(advance(shreg));
          end
        end
      end
      default: begin
        state_n = IDLE;
        shreg_n = '0;
        cnt_n   = '0;
        q_n     = 1'b0;
        qv_n    = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      q_r     <= 1'b0;
      qv_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= cnt_n;
      q_r     <= q_n;
      qv_r    <= qv_n;
      done_r  <= done_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first serializer share one
// stimulus stream and are compared every cycle against a bit-queue model.
module tb_piso_serializer;

  localparam int WIDTH = 4;

  logic             clock;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  piso_serializer_if #(.WIDTH(WIDTH)) ifm ();
  piso_serializer_if #(.WIDTH(WIDTH)) ifl ();

  assign ifm.load_valid = load_valid;
  assign ifm.load_data  = load_data;
  assign ifm.shift_en   = shift_en;
  assign ifl.load_valid = load_valid;
  assign ifl.load_data  = load_data;
  assign ifl.shift_en   = shift_en;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
    .clock (clock),
    .reset (reset),
    .bus   (ifm)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
    .clock (clock),
    .reset (reset),
    .bus   (ifl)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: each accepted word becomes WIDTH queued bits; one bit
  // leaves per enabled edge, and done follows the edge that empties a frame.
  bit   qm[$];
  bit   ql[$];
  bit   expDone = 1'b0;
  logic mRdy;
  logic mAcc;

  always @(posedge clock) begin
    if (reset) begin
      qm.delete();
      ql.delete();
      expDone = 1'b0;
    end else begin
      mRdy    = (qm.size() == 0) || (qm.size() == 1 && shift_en);
      mAcc    = load_valid && mRdy;
      expDone = 1'b0;
      if (qm.size() != 0 && shift_en) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
        if (qm.size() == 0) expDone = 1'b1;
      end
      if (mAcc) begin
        for (int i = 0; i < WIDTH; i++) begin
          qm.push_back(load_data[WIDTH-1-i]);
          ql.push_back(load_data[i]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("m_q",     32'(ifm.q),          32'(qm.size() != 0 ? qm[0] : 1'b0));
      checkOutput("l_q",     32'(ifl.q),          32'(ql.size() != 0 ? ql[0] : 1'b0));
      checkOutput("m_valid", 32'(ifm.q_valid),    32'(qm.size() != 0));
      checkOutput("l_valid", 32'(ifl.q_valid),    32'(qm.size() != 0));
      checkOutput("m_busy",  32'(ifm.busy),       32'(qm.size() != 0));
      checkOutput("l_busy",  32'(ifl.busy),       32'(qm.size() != 0));
      checkOutput("m_done",  32'(ifm.done),       32'(expDone));
      checkOutput("l_done",  32'(ifl.done),       32'(expDone));
      checkOutput("m_ready", 32'(ifm.load_ready),
                  32'((qm.size() == 0) || (qm.size() == 1 && shift_en)));
      checkOutput("l_ready", 32'(ifl.load_ready),
                  32'((qm.size() == 0) || (qm.size() == 1 && shift_en)));
    end
  end

  // Present inputs just after a rising edge; they are consumed at the next one.
  task automatic applyStimulus(input logic lv, input logic [WIDTH-1:0] ld,
                               input logic se, input logic rst);
    @(posedge clock);
    #1;
    load_valid = lv;
    load_data  = ld;
    shift_en   = se;
    reset      = rst;
  endtask

  logic [31:0] capQm, capQl, capV, capD;

  task automatic clearCap();
    capQm = '0;
    capQl = '0;
    capV  = '0;
    capD  = '0;
  endtask

  // Apply one cycle of inputs and record that cycle's outputs.
  task automatic stepCap(input logic lv, input logic [WIDTH-1:0] ld, input logic se);
    applyStimulus(lv, ld, se, 1'b0);
    @(negedge clock);
    capQm = {capQm[30:0], ifm.q};
    capQl = {capQl[30:0], ifl.q};
    capV  = {capV[30:0],  ifm.q_valid};
    capD  = {capD[30:0],  ifm.done};
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    load_valid = 1'b0;
    load_data  = '0;
    shift_en   = 1'b0;
    reset      = 1'b1;

    // Reset and check the idle state.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    checkEn = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("rst_q",     32'(ifm.q),          32'd0);
    checkOutput("rst_valid", 32'(ifm.q_valid),    32'd0);
    checkOutput("rst_busy",  32'(ifm.busy),       32'd0);
    checkOutput("rst_done",  32'(ifm.done),       32'd0);
    checkOutput("rst_ready", 32'(ifm.load_ready), 32'd1);

    // Single word 1011 at full rate, both bit orders.
    $display("[TB] single word 1011");
    clearCap();
    stepCap(1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 5; i++) stepCap(1'b0, 4'h0, 1'b1);
    checkOutput("t1_q_msb", capQm, 32'b010110);
    checkOutput("t1_q_lsb", capQl, 32'b011010);
    checkOutput("t1_valid", capV,  32'b011110);
    checkOutput("t1_done",  capD,  32'b000001);

    // Back-to-back A then 5 with load_valid held: no gap bit.
    $display("[TB] back-to-back A,5");
    clearCap();
    stepCap(1'b1, 4'hA, 1'b1);
    for (int i = 0; i < 4; i++) stepCap(1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 5; i++) stepCap(1'b0, 4'h0, 1'b1);
    checkOutput("t3_q_msb", capQm, 32'b0101001010);
    checkOutput("t3_valid", capV,  32'b0111111110);
    checkOutput("t3_done",  capD,  32'b0000010001);

    // Alternating shift_en on word C: each bit held two cycles.
    $display("[TB] stalled word C");
    clearCap();
    stepCap(1'b1, 4'hC, 1'b1);
    for (int i = 1; i <= 8; i++) stepCap(1'b0, 4'h0, (i % 2) == 0);
    stepCap(1'b0, 4'h0, 1'b1);
    checkOutput("t4_q_msb", capQm, 32'b0111100000);
    checkOutput("t4_valid", capV,  32'b0111111110);
    checkOutput("t4_done",  capD,  32'b0000000001);

    // Reset after the second bit of F aborts the frame.
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("t5_q",     32'(ifm.q),          32'd0);
    checkOutput("t5_valid", 32'(ifm.q_valid),    32'd0);
    checkOutput("t5_busy",  32'(ifm.busy),       32'd0);
    checkOutput("t5_ready", 32'(ifm.load_ready), 32'd1);
    checkOutput("t5_done",  32'(ifm.done),       32'd0);

    // load_valid mid-frame is ignored and the frame in flight is unchanged.
    $display("[TB] mid-frame load ignored");
    clearCap();
    stepCap(1'b1, 4'hA, 1'b1);
    stepCap(1'b0, 4'h0, 1'b1);
    stepCap(1'b1, 4'h5, 1'b1);
    checkOutput("t6_ready", 32'(ifm.load_ready), 32'd0);
    for (int i = 0; i < 4; i++) stepCap(1'b0, 4'h0, 1'b1);
    checkOutput("t6_q_msb", capQm, 32'b0101000);
    checkOutput("t6_valid", capV,  32'b0111100);

    // Randomized traffic with stalls, changing data and occasional resets.
    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter: the transmit-side counterpart of the team's 4-bit sipo shift register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock on a single serial line. It drives the d input of a sipo, or an off-chip serial link, with framing qualifiers (q_valid, done). Back-to-back words stream with no idle bit between them.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = load_data[WIDTH-1] sent first; 0 = load_data[0] sent first.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  producer has a word on load_data.
load_data  input  WIDTH  word to serialize; sampled only on accept.
load_ready  output  1  serializer can accept a word this cycle.
shift_en  input  1  bit-rate enable; a bit advances only on cycles where this is high.
q  output  1  serial data out, registered.
q_valid  output  1  q carries a frame bit this cycle.
busy  output  1  a frame is in progress (state SHIFT).
done  output  1  one-cycle pulse on the edge that retires the last bit of a frame.

Behaviour:
- Reset (reset=1 at an edge): state=IDLE, shift reg=0, bit_cnt=0, q=0, q_valid=0, busy=0, done=0. Reset mid-frame aborts the frame: no done, and remaining bits are discarded.
- Accept = load_valid && load_ready, evaluated at the rising edge.
- IDLE:
  - load_ready=1, q=0, q_valid=0.
  - On accept: capture load_data, go to SHIFT, bit_cnt=0, drive the first bit on q, set q_valid=1.
  - Latency: the first bit is visible on q in the cycle after the accept edge.
- SHIFT:
  - q holds the current bit; q_valid=1; busy=1.
  - With shift_en=0: everything holds, and q, q_valid and busy are unchanged (stall).
  - With shift_en=1 and bit_cnt<WIDTH-1: the next bit is driven on q and bit_cnt increments.
  - With shift_en=1 and bit_cnt==WIDTH-1 (last bit): done=1 for exactly that edge's following cycle.
    - If accept occurs on the same edge, reload, bit_cnt=0, drive the new first bit and stay in SHIFT. There is no gap bit.
    - Otherwise go to IDLE with q=0 and q_valid=0.
- load_ready in SHIFT = (bit_cnt==WIDTH-1) && shift_en. It is combinational from shift_en and never high at any other point in SHIFT.
- Each frame occupies exactly WIDTH cycles with shift_en=1 while q_valid=1.
- Bit order: the MSB_FIRST=1 sequence is load_data[WIDTH-1] down to [0]. The MSB_FIRST=0 sequence is [0] up to [WIDTH-1].
- Changes to load_data after accept have no effect on the frame in flight.
- bit_cnt width is $clog2(WIDTH) and it never exceeds WIDTH-1. There is no wrap beyond the last bit.
- load_valid while load_ready=0 is ignored, not queued. The producer must hold it.

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT};
  - localparam function for counter width, CNT_W = $clog2(WIDTH).
- Single module; no sub-module is warranted. The counter and shift register are inline.

Test Plan:
1. Reset, then load 4'b1011 with shift_en=1 and MSB_FIRST=1 -> q = 1,0,1,1 on cycles 1..4 after accept; q_valid high for 4 cycles; done pulses with the 4th bit; back to IDLE.
2. MSB_FIRST=0, load 4'b1011 -> q = 1,1,0,1; the loopback into a 4-bit sipo with MSB_FIRST=1 data 4'b0110 yields q4..q1=0,1,1,0 after 4 shifts.
3. Back-to-back 4'hA then 4'h5 with load_valid held -> 8 contiguous q_valid cycles with q=1,0,1,0,0,1,0,1; done pulses twice; no idle gap.
4. shift_en toggling 1,0,1,0... during frame 4'hC -> each bit held for 2 cycles; total 8 q_valid cycles; data correct.
5. reset=1 after the 2nd bit of 4'hF -> next cycle q=0, q_valid=0, busy=0, load_ready=1; no done.
6. load_valid during mid-frame (bit_cnt=1) -> load_ready=0, word not accepted, current frame unaffected.
